// File: rtl/pipe_mem_if.sv
// Request/response bus for pipe_mem: the requester is the master and the memory is the slave.
interface pipe_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/pipe_mem.sv
// Word memory with an RD_LAT-stage read pipeline, an in-order response FIFO and credit-based
// request flow control. Defining PIPE_MEM_PARITY_EN adds a stored even-parity bit per word.
module pipe_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  pipe_mem_if.slave bus
);
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int RQ_DEPTH = RD_LAT + 1;
  localparam int PTR_W    = $clog2(RQ_DEPTH);
  localparam int CNT_W    = $clog2(RQ_DEPTH + 1);
`ifdef PIPE_MEM_PARITY_EN
  localparam int MEM_W    = DATA_W + 1;
`else
  localparam int MEM_W    = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];
  logic              ready_en_q;
  logic              pv_q  [RD_LAT];
  logic [DATA_W-1:0] pd_q  [RD_LAT];
  logic              pe_q  [RD_LAT];
  logic [DATA_W-1:0] qd_q  [RQ_DEPTH];
  logic              qe_q  [RQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        outstanding;
  logic              accept, pop, push, in_range, rd_err;
  logic [DATA_W-1:0] rd_data;
  logic [MEM_W-1:0]  wr_word;

  // NOTE: always_comb uses blocking '=' so each partial sum is visible to the next line;
  // every always_ff below uses '<=' so all registers update from pre-edge values.
  always_comb begin
    outstanding = 4'(cnt_q);
    for (int i = 0; i < RD_LAT; i++) outstanding = outstanding + 4'(pv_q[i]);
  end

  assign in_range      = {1'b0, bus.req_addr} < (ADDR_W + 1)'(DEPTH);
  assign bus.rsp_valid = (cnt_q != '0);
  assign pop           = bus.rsp_valid & bus.rsp_ready;
  // A pop frees a credit in the same cycle, which sustains one request per cycle.
  assign bus.req_ready = ready_en_q & ((outstanding < 4'(RQ_DEPTH)) | pop);
  assign accept        = bus.req_valid & bus.req_ready;
  assign push          = pv_q[RD_LAT-1];
  assign bus.rsp_rdata = bus.rsp_valid ? qd_q[rd_ptr_q] : '0;
  assign bus.rsp_err   = bus.rsp_valid & qe_q[rd_ptr_q];

`ifdef PIPE_MEM_PARITY_EN
  assign wr_word = {^bus.req_wdata, bus.req_wdata};
`else
  assign wr_word = bus.req_wdata;
`endif

  always_comb begin
    rd_data = '0;
    rd_err  = ~in_range;
    if (in_range) begin
      rd_data = mem_q[bus.req_addr][DATA_W-1:0];
`ifdef PIPE_MEM_PARITY_EN
      rd_err  = ^mem_q[bus.req_addr];
`endif
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pv_q[i] <= 1'b0;
        pd_q[i] <= '0;
        pe_q[i] <= 1'b0;
      end
    end else begin
      ready_en_q <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      pv_q[0]    <= accept & ~bus.req_write;
      pd_q[0]    <= rd_data;
      pe_q[0]    <= rd_err;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  // NOTE: storage arrays are deliberately left out of reset; validity is tracked by
  // cnt_q and the pointers, and the memory must keep its contents across reset.
  always_ff @(posedge clk) begin
    if (push) begin
      qd_q[wr_ptr_q] <= pd_q[RD_LAT-1];
      qe_q[wr_ptr_q] <= pe_q[RD_LAT-1];
    end
    if (accept && bus.req_write && in_range) mem_q[bus.req_addr] <= wr_word;
  end
endmodule

// File: tb/tb_pipe_mem.sv
// Self-checking bench: two pipe_mem instances (DEPTH 32 and 20) share one stimulus stream and
// are checked every cycle against a queue-based response model plus directed literal checks.
module tb_pipe_mem;
  localparam int RD_LAT = 2;
  localparam int RQ     = RD_LAT + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid, req_write, rsp_ready;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;

  always #5 clk = ~clk;

  pipe_mem_if #(.DATA_W(8), .ADDR_W(5)) bus_a ();
  pipe_mem_if #(.DATA_W(8), .ADDR_W(5)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_write = req_write;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_write = req_write;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_wdata = req_wdata;
  assign bus_b.rsp_ready = rsp_ready;

  pipe_mem #(.DATA_W(8), .DEPTH(32), .RD_LAT(RD_LAT)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  pipe_mem #(.DATA_W(8), .DEPTH(20), .RD_LAT(RD_LAT)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted read becomes visible RD_LAT edges after its accept edge and leaves in order.
  typedef struct {
    logic [7:0] d_a;
    logic       e_a;
    logic [7:0] d_b;
    logic       e_b;
    int         due;
  } rsp_t;

  rsp_t       pend[$];
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  bit         bad_a [32];
  logic [7:0] got_a[$], got_b[$];
  bit         gerr_a[$], gerr_b[$];
  int         edges = 0;
  int         vseen = 0;
  bit         en = 1'b0;

  always @(posedge clk) edges++;

  always @(negedge clk) begin
    bit   ev, pop, er;
    rsp_t r;
    if (!rst_n) begin
      pend.delete();
      en = 1'b0;
      check("rst_req_ready_a", bus_a.req_ready, 0);
      check("rst_rsp_valid_a", bus_a.rsp_valid, 0);
      check("rst_rsp_rdata_a", bus_a.rsp_rdata, 0);
      check("rst_rsp_err_a",   bus_a.rsp_err,   0);
      check("rst_req_ready_b", bus_b.req_ready, 0);
      check("rst_rsp_valid_b", bus_b.rsp_valid, 0);
    end else begin
      ev  = (pend.size() > 0) && (pend[0].due <= edges);
      pop = ev && rsp_ready;
      er  = en && ((pend.size() < RQ) || pop);
      check("req_ready_a", bus_a.req_ready, er);
      check("req_ready_b", bus_b.req_ready, er);
      check("rsp_valid_a", bus_a.rsp_valid, ev);
      check("rsp_valid_b", bus_b.rsp_valid, ev);
      if (ev) begin
        check("rsp_rdata_a", bus_a.rsp_rdata, pend[0].d_a);
        check("rsp_err_a",   bus_a.rsp_err,   pend[0].e_a);
        check("rsp_rdata_b", bus_b.rsp_rdata, pend[0].d_b);
        check("rsp_err_b",   bus_b.rsp_err,   pend[0].e_b);
      end
      if (bus_a.rsp_valid) vseen++;
      if (pop) begin
        got_a.push_back(pend[0].d_a);
        gerr_a.push_back(pend[0].e_a);
        got_b.push_back(pend[0].d_b);
        gerr_b.push_back(pend[0].e_b);
        void'(pend.pop_front());
      end
      if (er && req_valid) begin
        if (req_write) begin
          mem_a[req_addr] = req_wdata;
          bad_a[req_addr] = 1'b0;
          if (req_addr < 20) mem_b[req_addr] = req_wdata;
        end else begin
          r.d_a = mem_a[req_addr];
          r.e_a = bad_a[req_addr];
          r.d_b = (req_addr < 20) ? mem_b[req_addr] : 8'h00;
          r.e_b = (req_addr >= 20);
          r.due = edges + 1 + RD_LAT;
          pend.push_back(r);
        end
      end
      en = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_a.delete();
    got_b.delete();
    gerr_a.delete();
    gerr_b.delete();
  endtask

  task automatic issue(input bit wr, input logic [4:0] a, input logic [7:0] d);
    bit acc = 1'b0;
    int budget = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = bus_a.req_ready;
      step();
      budget++;
    end
    check("issue_accepted", acc, 1);
    req_valid = 1'b0;
  endtask

  initial begin
    int acc;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_low_before_first_edge", bus_a.req_ready, 0);
    @(negedge clk);
    check("ready_high_after_first_edge", bus_a.req_ready, 1);
    step();

    for (int i = 0; i < 32; i++) issue(1'b1, 5'(i), 8'h80 | 8'(i));
    issue(1'b1, 5'd19, 8'h5A);

    // Write then read the same address on consecutive accepts.
    issue(1'b1, 5'd3, 8'hA5);
    issue(1'b0, 5'd3, 8'h00);
    @(negedge clk);
    check("s1_valid_after_1_edge", bus_a.rsp_valid, 0);
    @(negedge clk);
    check("s1_valid_after_2_edges", bus_a.rsp_valid, 0);
    @(negedge clk);
    check("s1_valid_at_latency", bus_a.rsp_valid, 1);
    check("s1_rdata", bus_a.rsp_rdata, 8'hA5);
    check("s1_err", bus_a.rsp_err, 0);
    step();
    repeat (3) step();

    // Top address, then address 0, delivered in order.
    clear_log();
    issue(1'b1, 5'd31, 8'h11);
    issue(1'b1, 5'd0, 8'h22);
    issue(1'b0, 5'd31, 8'h00);
    issue(1'b0, 5'd0, 8'h00);
    repeat (5) step();
    check("s2_count", got_a.size(), 2);
    check("s2_first", got_a[0], 8'h11);
    check("s2_second", got_a[1], 8'h22);
    check("s2_b_oor_err", gerr_b[0], 1);
    check("s2_b_oor_data", got_b[0], 8'h00);

    // Out-of-range on the DEPTH=20 instance.
    clear_log();
    issue(1'b0, 5'd25, 8'h00);
    repeat (5) step();
    check("s3_b_oor_data", got_b[0], 8'h00);
    check("s3_b_oor_err", gerr_b[0], 1);
    check("s3_a_data", got_a[0], 8'h99);
    issue(1'b1, 5'd25, 8'hFF);
    issue(1'b0, 5'd19, 8'h00);
    repeat (5) step();
    check("s3_b_last_data", got_b[1], 8'h5A);
    check("s3_b_last_err", gerr_b[1], 0);
    check("s3_a_last_data", got_a[1], 8'h5A);

    // Back-pressure: credits run out at RQ outstanding reads.
    clear_log();
    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'd5;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus_a.req_ready) acc++;
      step();
      req_addr = 5'(5 + acc);
    end
    check("s4_accepted", acc, 3);
    @(negedge clk);
    check("s4_ready_stalled", bus_a.req_ready, 0);
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("s4_ready_on_first_pop", bus_a.req_ready, 1);
    step();
    repeat (5) step();
    check("s4_count", got_a.size(), 3);
    check("s4_rsp0", got_a[0], 8'h85);
    check("s4_rsp1", got_a[1], 8'h86);
    check("s4_rsp2", got_a[2], 8'h87);

    // Sustained throughput with rsp_ready held high.
    clear_log();
    acc = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      req_addr = 5'(8 + c);
      @(negedge clk);
      if (bus_a.req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    check("thru_accepted", acc, 8);
    repeat (6) step();
    check("thru_count", got_a.size(), 8);
    check("thru_first", got_a[0], 8'h88);
    check("thru_last", got_a[7], 8'h8F);

    // Reset pulse with two reads in flight.
    clear_log();
    vseen = 0;
    issue(1'b0, 5'd10, 8'h00);
    issue(1'b0, 5'd11, 8'h00);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check("s5_no_rsp_after_reset", vseen, 0);
    issue(1'b0, 5'd3, 8'h00);
    repeat (5) step();
    check("s5_count", got_a.size(), 1);
    check("s5_mem_kept", got_a[0], 8'hA5);

`ifdef PIPE_MEM_PARITY_EN
    clear_log();
    dut_a.mem_q[7] = dut_a.mem_q[7] ^ 9'h001;
    mem_a[7] = mem_a[7] ^ 8'h01;
    bad_a[7] = 1'b1;
    issue(1'b0, 5'd7, 8'h00);
    repeat (5) step();
    check("s6_parity_err", gerr_a[0], 1);
    check("s6_parity_data", got_a[0], 8'h86);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_mem.md
PIPE_MEM -- requirements
Module: pipe_mem

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 32: number of words, legal range 2..1024; need not be a power of two.
REQ-003 Parameter RD_LAT, default 1: read pipeline latency in cycles, legal range 1..3.
REQ-004 Derived constants: ADDR_W = $clog2(DEPTH); RQ_DEPTH = RD_LAT+1 (response queue depth).
REQ-005 Ports, one clock; reset is asynchronous and active-low:
- clk        in   1        rising-edge clock.
- rst_n      in   1        asynchronous active-low reset.
- req_valid  in   1        request present.
- req_ready  out  1        request can be accepted.
- req_write  in   1        1 = write, 0 = read.
- req_addr   in   ADDR_W   word address.
- req_wdata  in   DATA_W   write data.
- rsp_valid  out  1        read response present.
- rsp_ready  in   1        consumer accepts the response.
- rsp_rdata  out  DATA_W   read data.
- rsp_err    out  1        response is for an out-of-range address, or has a parity fault (see REQ-019).

Function
REQ-006 A request is accepted on a rising clk edge where req_valid and req_ready are both 1; nothing else is accepted.
REQ-007 Accepted write, req_addr < DEPTH: mem[req_addr] <= req_wdata at that edge. No response is generated for a write.
REQ-008 Accepted write, req_addr >= DEPTH: memory is unchanged; no response and no error are generated.
REQ-009 Accepted read: the memory is sampled at the acceptance edge. Write-then-read to the same address on consecutive accepts returns the new data.
REQ-010 A read response enters the response queue RD_LAT cycles after acceptance. With the queue empty and rsp_ready=1, rsp_valid is first high RD_LAT cycles after the accept edge.
REQ-011 A read with req_addr >= DEPTH returns rsp_rdata=0 and rsp_err=1, with the same latency.
REQ-012 The response queue is a FIFO of RQ_DEPTH entries. Responses are delivered strictly in acceptance order.
REQ-013 rsp_valid, rsp_rdata and rsp_err hold stable while rsp_valid=1 and rsp_ready=0. A response pops on an edge where rsp_valid=1 and rsp_ready=1.
REQ-014 Credit rule: outstanding = reads in the pipeline + queue entries. req_ready = (outstanding < RQ_DEPTH), or (a pop occurs this cycle). req_ready applies to writes and reads alike.
REQ-015 Pop and enqueue on the same edge keep the queue occupancy unchanged. The queue never overflows.
REQ-016 req_ready is combinational from internal state and rsp_ready only. It has no path from req_valid.
REQ-017 Sustained throughput is 1 request per cycle when rsp_ready is held at 1.

Reset
REQ-018 While rst_n=0:
- req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Pipeline and queue are emptied.
- Memory contents are not reset.
- In-flight reads are discarded, including reset asserted mid-operation.
- req_ready rises on the first clk edge after rst_n deasserts.

Configuration
REQ-019 Macro PIPE_MEM_PARITY_EN, when defined:
- Each word stores an extra even-parity bit, computed at write time.
- Parity is checked on read; a mismatch sets rsp_err=1 for that response, with rsp_rdata still returned.
- When the macro is undefined, no parity storage exists and rsp_err reflects only REQ-011.

Verification
REQ-020 Scenario 1 (DATA_W=8, DEPTH=32, RD_LAT=2): write 0xA5 to addr 3, then read addr 3 on the next cycle with rsp_ready=1 -> rsp_valid=1 exactly 2 cycles after the read accept, rsp_rdata=0xA5, rsp_err=0.
REQ-021 Scenario 2: read addr 31 then addr 0 after writing 0x11/0x22 to them -> responses 0x11 then 0x22, in order; address 31 works, no wrap to 0.
REQ-022 Scenario 3 (DEPTH=20): read addr 25 -> rsp_rdata=0x00, rsp_err=1. Write 0xFF to addr 25, then read addr 19 (previously 0x5A) -> 0x5A, rsp_err=0.
REQ-023 Scenario 4: rsp_ready=0, issue reads back-to-back -> exactly 3 accepted (RQ_DEPTH=3), then req_ready=0. Raise rsp_ready -> 3 ordered responses, and req_ready returns the same cycle as the first pop.
REQ-024 Scenario 5: two reads in flight, pulse rst_n low for 1 cycle -> no rsp_valid afterwards; memory still returns previously written data.
REQ-025 Scenario 6 (PIPE_MEM_PARITY_EN defined): force-flip one stored bit of addr 7 via the bench, then read addr 7 -> rsp_err=1.
